univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 16 +
 rtl/univ_shift_reg_sat_counter.sv | 31 +++
 rtl/univ_shift_reg.sv | 74 +++++++
 tb/tb_univ_shift_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and a small decode helper, also used by the doorlock key-entry logic.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == SHR) || (mode == SHL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating fill counter: counts shifted-in bits since the last clear,
// jumps straight to MAX on a parallel load.
module sat_counter #(
    parameter int MAX = 4,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          inc,
    input  logic          load_max,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load_max) begin
            r_count <= CW'(MAX);
        end else if (inc && (r_count != CW'(MAX))) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-right / shift-left / parallel load,
// with a registered serial-out bit and a saturating fill count.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             CLR,
    input  logic             SIN,
    input  logic [WIDTH-1:0] PIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic [CW-1:0]    COUNT,
    output logic             FULL
);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;
    logic             w_inc;
    logic             w_load;
    logic [CW-1:0]    w_count;

    always_comb begin
        w_q_next    = r_q;
        w_sout_next = r_sout;
        case (mode_e'(MODE))
            SHR: begin
                w_q_next    = {SIN, r_q[WIDTH-1:1]};
                w_sout_next = r_q[0];
            end
            SHL: begin
                w_q_next    = {r_q[WIDTH-2:0], SIN};
                w_sout_next = r_q[WIDTH-1];
            end
            LOAD:    w_q_next = PIN;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST || CLR) begin
            r_q    <= '0;
            r_sout <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_sout <= w_sout_next;
        end
    end

    assign w_inc  = is_shift(MODE);
    assign w_load = (MODE == LOAD);

    sat_counter #(.MAX(WIDTH)) u_fill (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (CLR),
        .inc      (w_inc),
        .load_max (w_load),
        .count    (w_count)
    );

    // FULL is a pure decode of the registered count, so it carries no state.
    assign Q     = r_q;
    assign SOUT  = r_sout;
    assign COUNT = w_count;
    assign FULL  = (w_count == CW'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, clr4, sin4;
    logic [1:0] mode4;
    logic [3:0] pin4, q4;
    logic       sout4, full4;
    logic [2:0] count4;

    logic       rst8, clr8, sin8;
    logic [1:0] mode8;
    logic [7:0] pin8, q8;
    logic       sout8, full8;
    logic [3:0] count8;

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST(rst4), .MODE(mode4), .CLR(clr4), .SIN(sin4), .PIN(pin4),
        .Q(q4), .SOUT(sout4), .COUNT(count4), .FULL(full4)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst8), .MODE(mode8), .CLR(clr8), .SIN(sin8), .PIN(pin8),
        .Q(q8), .SOUT(sout8), .COUNT(count8), .FULL(full8)
    );

    typedef struct {
        logic [31:0] q4;
        logic        s4;
        int          c4;
        logic [31:0] q8;
        logic        s8;
        int          c8;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    logic [31:0] m4_q = 0, m8_q = 0;
    logic        m4_s = 0, m8_s = 0;
    int          m4_c = 0, m8_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behaviour from the operation rules, using plain integer arithmetic.
    task automatic model(input int w, input logic rst, input logic clr, input logic [1:0] mode,
                         input logic sin, input logic [31:0] pin,
                         inout logic [31:0] q, inout logic s, inout int c);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        if (!rst || clr) begin
            q = 0; s = 0; c = 0;
        end else if (mode == 2'b01) begin
            s = q[0];
            q = (q >> 1) | (32'(sin) << (w - 1));
            c = (c + 1 > w) ? w : c + 1;
        end else if (mode == 2'b10) begin
            s = q[w-1];
            q = ((q << 1) | 32'(sin)) & mask;
            c = (c + 1 > w) ? w : c + 1;
        end else if (mode == 2'b11) begin
            q = pin & mask;
            c = w;
        end
    endtask

    task automatic tick();
        exp_t x;
        model(4, rst4, clr4, mode4, sin4, 32'(pin4), m4_q, m4_s, m4_c);
        model(8, rst8, clr8, mode8, sin8, 32'(pin8), m8_q, m8_s, m8_c);
        x.q4 = m4_q; x.s4 = m4_s; x.c4 = m4_c;
        x.q8 = m8_q; x.s8 = m8_s; x.c8 = m8_c;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic op4(input logic rst, input logic clr, input logic [1:0] mode,
                       input logic sin, input logic [3:0] pin);
        rst4 = rst; clr4 = clr; mode4 = mode; sin4 = sin; pin4 = pin;
        rst8 = 1'b1; clr8 = 1'b0; mode8 = 2'b00; sin8 = 1'b0; pin8 = 8'h00;
        tick();
    endtask

    task automatic op8(input logic rst, input logic clr, input logic [1:0] mode,
                       input logic sin, input logic [7:0] pin);
        rst8 = rst; clr8 = clr; mode8 = mode; sin8 = sin; pin8 = pin;
        rst4 = 1'b1; clr4 = 1'b0; mode4 = 2'b00; sin4 = 1'b0; pin4 = 4'h0;
        tick();
    endtask

    // Monitor: outputs are registered, so every edge presents a new response.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_q4",     32'(q4),     e.q4);
            chk("sb_sout4",  32'(sout4),  32'(e.s4));
            chk("sb_count4", 32'(count4), 32'(e.c4));
            chk("sb_full4",  32'(full4),  32'(e.c4 == 4));
            chk("sb_q8",     32'(q8),     e.q8);
            chk("sb_sout8",  32'(sout8),  32'(e.s8));
            chk("sb_count8", 32'(count8), 32'(e.c8));
            chk("sb_full8",  32'(full8),  32'(e.c8 == 8));
        end
    end

    initial begin
        rst4 = 0; clr4 = 0; mode4 = 0; sin4 = 0; pin4 = 0;
        rst8 = 0; clr8 = 0; mode8 = 0; sin8 = 0; pin8 = 0;

        // Reset of both instances.
        rst8 = 1'b0;
        op4(0, 0, 2'b11, 1, 4'hF);
        rst8 = 1'b0;
        op4(0, 0, 2'b01, 1, 4'h0);
        chk("rst_q4", 32'(q4), 0);
        chk("rst_count4", 32'(count4), 0);
        chk("rst_full4", 32'(full4), 0);
        chk("rst_sout4", 32'(sout4), 0);

        // Serial fill to full by shifting right 1,0,1,1.
        op4(1, 0, 2'b01, 1, 0);
        op4(1, 0, 2'b01, 0, 0);
        op4(1, 0, 2'b01, 1, 0);
        op4(1, 0, 2'b01, 1, 0);
        chk("shr_fill_q", 32'(q4), 32'b1101);
        chk("shr_fill_count", 32'(count4), 4);
        chk("shr_fill_full", 32'(full4), 1);
        chk("shr_fill_sout", 32'(sout4), 0);

        // Load then shift left twice: the loaded MSB leaves first.
        op4(1, 0, 2'b11, 0, 4'b1001);
        op4(1, 0, 2'b10, 0, 0);
        chk("shl1_q", 32'(q4), 32'b0010);
        chk("shl1_sout", 32'(sout4), 1);
        op4(1, 0, 2'b10, 0, 0);
        chk("shl2_q", 32'(q4), 32'b0100);
        chk("shl2_sout", 32'(sout4), 0);
        chk("shl2_count", 32'(count4), 4);

        // Saturation: six shift-rights of 1 after a clear.
        op4(1, 1, 2'b00, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            op4(1, 0, 2'b01, 1, 0);
            if (i == 3) chk("sat3_full", 32'(full4), 0);
            if (i == 4) chk("sat4_count", 32'(count4), 4);
            if (i >= 5) chk("sat_sout", 32'(sout4), 1);
        end
        chk("sat_q", 32'(q4), 32'hF);
        chk("sat_count", 32'(count4), 4);

        // Clear wins over a simultaneous load.
        op4(1, 1, 2'b11, 0, 4'hF);
        chk("clr_load_q", 32'(q4), 0);
        chk("clr_load_count", 32'(count4), 0);
        chk("clr_load_full", 32'(full4), 0);

        // Reset mid-fill abandons the partial count.
        op4(1, 0, 2'b01, 1, 0);
        op4(1, 0, 2'b01, 0, 0);
        chk("mid_count", 32'(count4), 2);
        op4(0, 0, 2'b01, 1, 0);
        op4(1, 0, 2'b01, 1, 0);
        chk("post_rst_q", 32'(q4), 32'b1000);
        chk("post_rst_count", 32'(count4), 1);

        // WIDTH=8 alternating directions with SIN=1.
        op8(0, 0, 2'b00, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            op8(1, 0, (i % 2 == 1) ? 2'b01 : 2'b10, 1, 0);
            if (i == 7) chk("alt7_full8", 32'(full8), 0);
            if (i == 8) chk("alt8_full8", 32'(full8), 1);
        end

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            rst4  = ($urandom_range(0, 39) != 0);
            clr4  = ($urandom_range(0, 19) == 0);
            mode4 = 2'($urandom);
            sin4  = 1'($urandom);
            pin4  = 4'($urandom);
            rst8  = ($urandom_range(0, 39) != 0);
            clr8  = ($urandom_range(0, 19) == 0);
            mode8 = 2'($urandom);
            sin8  = 1'($urandom);
            pin8  = 8'($urandom);
            tick();
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
